systolic_mm_engine: RTL and testbench

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

---
 rtl/systolic_mm_engine_if.sv | 29 ++
 rtl/systolic_mm_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_mm_engine_if.sv
// Operand-stream and result-stream bundle for the systolic matrix-multiply engine.
// master: the producer/consumer side; slave: the engine side.
interface systolic_mm_engine_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int ROWS   = 4,
    parameter int COLS   = 4
);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS*DATA_W-1:0]  a_col;
    logic [COLS*DATA_W-1:0]  b_row;
    logic                    out_valid;
    logic                    out_ready;
    logic [COLS*ACC_W-1:0]   out_row;
    logic [IDX_W-1:0]        out_idx;

    modport master (
        output in_valid, a_col, b_row, out_ready,
        input  in_ready, out_valid, out_row, out_idx
    );

    modport slave (
        input  in_valid, a_col, b_row, out_ready,
        output in_ready, out_valid, out_row, out_idx
    );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic array computing C = A * B.
// A columns and B rows stream in one beat per accepted handshake; after a
// flush the accumulated rows of C are drained one row per handshake.
module systolic_mm_engine #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int KW     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    systolic_mm_engine_if.slave  bus,
    output logic                 busy,
    output logic                 done
);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FLW   = $clog2(ROWS + COLS);
    localparam int PW    = 2 * DATA_W;

    typedef enum logic [2:0] {StIdle, StFeed, StFlush, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [KW-1:0]      k_len_q, k_len_d;
    logic [KW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [FLW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [IDX_W-1:0]   row_idx_q, row_idx_d;
    logic               clear;
    logic               beat_acc;
    logic               shift_en;

    logic signed [DATA_W-1:0] a_in   [ROWS];
    logic signed [DATA_W-1:0] b_in   [COLS];
    logic signed [DATA_W-1:0] a_feed [ROWS];
    logic signed [DATA_W-1:0] b_feed [COLS];

    logic signed [DATA_W-1:0] a_pe_q [ROWS][COLS];
    logic signed [DATA_W-1:0] b_pe_q [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_q  [ROWS][COLS];
    logic signed [DATA_W-1:0] a_left [ROWS][COLS];
    logic signed [DATA_W-1:0] b_up   [ROWS][COLS];
    logic signed [PW-1:0]     prod   [ROWS][COLS];

    assign beat_acc = (state_q == StFeed) && bus.in_valid;
    assign shift_en = (state_q == StFeed) || (state_q == StFlush);

    // Control state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            row_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            row_idx_q   <= row_idx_d;
        end
    end

    // Next-state logic: job start, beat counting, flush timing, row drain
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        row_idx_d   = row_idx_q;
        clear       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && (k_len != '0)) begin
                    clear       = 1'b1;
                    k_len_d     = k_len;
                    beat_cnt_d  = '0;
                    flush_cnt_d = '0;
                    row_idx_d   = '0;
                    state_d     = StFeed;
                end
            end
            StFeed: begin
                if (bus.in_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_d == k_len_q) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                // Last beat needs ROWS+COLS-1 cycles to reach the far corner PE
                if (flush_cnt_q == FLW'(ROWS + COLS - 2)) begin
                    state_d = StDrain;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (bus.out_ready) begin
                    if (row_idx_q == IDX_W'(ROWS - 1)) begin
                        row_idx_d = '0;
                        state_d   = StDone;
                    end else begin
                        row_idx_d = row_idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status and result outputs; out_row is forced to zero outside DRAIN
    always_comb begin
        bus.in_ready  = (state_q == StFeed);
        bus.out_valid = (state_q == StDrain);
        bus.out_idx   = row_idx_q;
        busy          = (state_q != StIdle);
        done          = (state_q == StDone);
        bus.out_row   = '0;
        if (state_q == StDrain) begin
            for (int j = 0; j < COLS; j++) begin
                bus.out_row[j*ACC_W +: ACC_W] = acc_q[row_idx_q][j];
            end
        end
    end

    // Lane extraction; zeros are injected whenever no beat is accepted
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_in[i] = beat_acc ? bus.a_col[i*DATA_W +: DATA_W] : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            b_in[j] = beat_acc ? bus.b_row[j*DATA_W +: DATA_W] : '0;
        end
    end

    // A skew: lane i delayed by i cycles before entering PE(i,0)
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign a_feed[i] = a_in[i];
        end else begin : g_dly
            logic signed [DATA_W-1:0] sk_q [i];
            // Shift register advancing with the array
            always_ff @(posedge clk) begin
                if (!rst_n || clear) begin
                    for (int d = 0; d < i; d++) sk_q[d] <= '0;
                end else if (shift_en) begin
                    sk_q[0] <= a_in[i];
                    for (int d = 1; d < i; d++) sk_q[d] <= sk_q[d-1];
                end
            end
            assign a_feed[i] = sk_q[i-1];
        end
    end

    // B skew: lane j delayed by j cycles before entering PE(0,j)
    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign b_feed[j] = b_in[j];
        end else begin : g_dly
            logic signed [DATA_W-1:0] sk_q [j];
            // Shift register advancing with the array
            always_ff @(posedge clk) begin
                if (!rst_n || clear) begin
                    for (int d = 0; d < j; d++) sk_q[d] <= '0;
                end else if (shift_en) begin
                    sk_q[0] <= b_in[j];
                    for (int d = 1; d < j; d++) sk_q[d] <= sk_q[d-1];
                end
            end
            assign b_feed[j] = sk_q[j-1];
        end
    end

    // PE neighbour wiring and signed products
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_left[i][0] = a_feed[i];
            for (int j = 1; j < COLS; j++) a_left[i][j] = a_pe_q[i][j-1];
        end
        for (int j = 0; j < COLS; j++) begin
            b_up[0][j] = b_feed[j];
            for (int i = 1; i < ROWS; i++) b_up[i][j] = b_pe_q[i-1][j];
        end
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                prod[i][j] = PW'(a_pe_q[i][j]) * PW'(b_pe_q[i][j]);
            end
        end
    end

    // PE array: operands shift right/down, accumulators wrap modulo 2^ACC_W
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    a_pe_q[i][j] <= '0;
                    b_pe_q[i][j] <= '0;
                    acc_q[i][j]  <= '0;
                end
            end
        end else if (shift_en) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    a_pe_q[i][j] <= a_left[i][j];
                    b_pe_q[i][j] <= b_up[i][j];
                    acc_q[i][j]  <= acc_q[i][j] + ACC_W'(prod[i][j]);
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: identity, signed, mixed, stalls,
// backpressure, 32-bit wrap, zero-length start and reset during FLUSH.
module tb_systolic_mm_engine;
    localparam int DW = 16;
    localparam int AW = 40;
    localparam int AW2 = 32;
    localparam int R = 4;
    localparam int C = 4;
    localparam int KWL = 8;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [KWL-1:0]  k_len;
    logic            in_valid;
    logic            out_ready;
    logic [R*DW-1:0] a_col;
    logic [C*DW-1:0] b_row;
    logic            busy, done, busy2, done2;

    systolic_mm_engine_if #(.DATA_W(DW), .ACC_W(AW), .ROWS(R), .COLS(C)) bus ();
    systolic_mm_engine_if #(.DATA_W(DW), .ACC_W(AW2), .ROWS(R), .COLS(C)) bus2 ();

    assign bus.in_valid   = in_valid;
    assign bus.a_col      = a_col;
    assign bus.b_row      = b_row;
    assign bus.out_ready  = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.a_col     = a_col;
    assign bus2.b_row     = b_row;
    assign bus2.out_ready = out_ready;

    systolic_mm_engine #(.DATA_W(DW), .ACC_W(AW), .ROWS(R), .COLS(C), .KW(KWL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .k_len (k_len),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    systolic_mm_engine #(.DATA_W(DW), .ACC_W(AW2), .ROWS(R), .COLS(C), .KW(KWL)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .k_len (k_len),
        .bus   (bus2),
        .busy  (busy2),
        .done  (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [DW-1:0] mat_a [R][8];
    logic signed [DW-1:0] mat_b [8][C];
    logic [AW-1:0]        exp_c [R][C];
    logic [AW2-1:0]       exp32;
    bit                   chk32;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp_row(input int i, input int c0, input int c1, input int c2,
                               input int c3);
        exp_c[i][0] = AW'(c0);
        exp_c[i][1] = AW'(c1);
        exp_c[i][2] = AW'(c2);
        exp_c[i][3] = AW'(c3);
    endtask

    task automatic fill_all(input int av, input int bv, input int cv);
        for (int i = 0; i < R; i++) for (int k = 0; k < 8; k++) mat_a[i][k] = DW'(av);
        for (int k = 0; k < 8; k++) for (int j = 0; j < C; j++) mat_b[k][j] = DW'(bv);
        for (int i = 0; i < R; i++) set_exp_row(i, cv, cv, cv, cv);
    endtask

    task automatic check_row(input string tag, input int r);
        for (int j = 0; j < C; j++) begin
            check_eq($sformatf("%s row%0d col%0d", tag, r, j),
                     64'(bus.out_row[j*AW +: AW]), 64'(exp_c[r][j]));
            if (chk32) begin
                check_eq($sformatf("%s w32 row%0d col%0d", tag, r, j),
                         64'(bus2.out_row[j*AW2 +: AW2]), 64'(exp32));
            end
        end
    endtask

    // One complete job: start, feed k beats (gap idle cycles between beats),
    // flush, drain (optionally holding one row for hold_cycles), done.
    task automatic run_job(input int k, input int gap, input int hold_row, input int hold_cycles,
                           input string tag);
        int cyc;
        int n;
        start = 1'b1;
        k_len = KWL'(k);
        tick();
        cyc = 1;
        start = 1'b0;
        check_eq({tag, " busy"}, 64'(busy), 64'd1);
        for (int kk = 0; kk < k; kk++) begin
            if (kk > 0) begin
                repeat (gap) begin
                    // A start request while busy must not disturb the job
                    in_valid = 1'b0;
                    start = 1'b1;
                    k_len = 8'd1;
                    tick();
                    cyc++;
                end
                start = 1'b0;
            end
            for (int i = 0; i < R; i++) a_col[i*DW +: DW] = mat_a[i][kk];
            for (int j = 0; j < C; j++) b_row[j*DW +: DW] = mat_b[kk][j];
            in_valid = 1'b1;
            if (kk == 0) check_eq({tag, " first ready"}, 64'(bus.in_ready), 64'd1);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        a_col = '0;
        b_row = '0;
        check_eq({tag, " ready in flush"}, 64'(bus.in_ready), 64'd0);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
            cyc++;
        end
        check_eq({tag, " flush len"}, 64'(n), 64'd7);
        for (int r = 0; r < R; r++) begin
            check_eq($sformatf("%s valid row%0d", tag, r), 64'(bus.out_valid), 64'd1);
            check_eq($sformatf("%s idx row%0d", tag, r), 64'(bus.out_idx), 64'(r));
            check_row(tag, r);
            if (r == hold_row) begin
                out_ready = 1'b0;
                repeat (hold_cycles) tick();
                cyc += hold_cycles;
                check_eq($sformatf("%s held idx%0d", tag, r), 64'(bus.out_idx), 64'(r));
                check_eq({tag, " no done in hold"}, 64'(done), 64'd0);
                check_row({tag, " held"}, r);
                out_ready = 1'b1;
            end
            tick();
            cyc++;
        end
        check_eq({tag, " done"}, 64'(done), 64'd1);
        check_eq({tag, " valid in done"}, 64'(bus.out_valid), 64'd0);
        if (gap == 0 && hold_cycles == 0) begin
            check_eq({tag, " latency"}, 64'(cyc + 1), 64'(1 + k + 7 + 4 + 1));
        end
        tick();
        check_eq({tag, " done pulse"}, 64'(done), 64'd0);
        check_eq({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
        check_eq({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, " out_row"}, 64'(bus.out_row), 64'd0);
        check_eq({tag, " out_idx"}, 64'(bus.out_idx), 64'd0);
        check_eq({tag, " busy"}, 64'(busy), 64'd0);
        check_eq({tag, " done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        k_len = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a_col = '0;
        b_row = '0;
        chk32 = 1'b0;
        exp32 = '0;
        repeat (3) tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // Beats offered in IDLE are not taken
        in_valid = 1'b1;
        a_col = 64'h1234_5678_9abc_def0;
        b_row = 64'h0fed_cba9_8765_4321;
        repeat (2) tick();
        check_eq("idle ignores beat", 64'(bus.in_ready), 64'd0);
        in_valid = 1'b0;
        a_col = '0;
        b_row = '0;

        // Zero-length start is ignored
        start = 1'b1;
        k_len = '0;
        tick();
        start = 1'b0;
        tick();
        check_eq("k0 busy", 64'(busy), 64'd0);
        check_eq("k0 in_ready", 64'(bus.in_ready), 64'd0);

        // Identity A, B[k][j] = 10k + j -> C = B
        fill_all(0, 0, 0);
        for (int i = 0; i < R; i++) mat_a[i][i] = 16'sd1;
        for (int k = 0; k < 4; k++) for (int j = 0; j < C; j++) mat_b[k][j] = DW'(10 * k + j);
        set_exp_row(0, 0, 1, 2, 3);
        set_exp_row(1, 10, 11, 12, 13);
        set_exp_row(2, 20, 21, 22, 23);
        set_exp_row(3, 30, 31, 32, 33);
        run_job(4, 0, -1, 0, "ident");

        // Backpressure on row 2 for 5 cycles, same operands
        run_job(4, 0, 2, 5, "bp");

        // Signed: -3 * 5
        fill_all(-3, 5, -15);
        run_job(1, 0, -1, 0, "signed");

        // Mixed-sign 4x3 * 3x4, then the same job with 2 idle cycles between beats
        fill_all(0, 0, 0);
        mat_a[0][0] = 16'sd1;  mat_a[0][1] = 16'sd2;  mat_a[0][2] = 16'sd3;
        mat_a[1][0] = -16'sd1; mat_a[1][1] = 16'sd0;  mat_a[1][2] = 16'sd2;
        mat_a[2][0] = 16'sd4;  mat_a[2][1] = -16'sd2; mat_a[2][2] = 16'sd1;
        mat_a[3][0] = 16'sd0;  mat_a[3][1] = 16'sd3;  mat_a[3][2] = -16'sd1;
        mat_b[0][0] = 16'sd1;  mat_b[0][1] = 16'sd0;  mat_b[0][2] = 16'sd2;  mat_b[0][3] = -16'sd1;
        mat_b[1][0] = 16'sd3;  mat_b[1][1] = 16'sd1;  mat_b[1][2] = 16'sd0;  mat_b[1][3] = 16'sd2;
        mat_b[2][0] = -16'sd2; mat_b[2][1] = 16'sd4;  mat_b[2][2] = 16'sd1;  mat_b[2][3] = 16'sd1;
        set_exp_row(0, 1, 14, 5, 6);
        set_exp_row(1, -5, 8, 0, 3);
        set_exp_row(2, -4, 2, 9, -7);
        set_exp_row(3, 11, -1, -1, 5);
        run_job(3, 0, -1, 0, "mix");
        run_job(3, 2, -1, 0, "stall");

        // Wrap: 3 * (-32768)^2 = 3 * 2^30
        fill_all(-32768, -32768, 0);
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) exp_c[i][j] = 40'h00_C000_0000;
        exp32 = 32'hC000_0000;
        chk32 = 1'b1;
        run_job(3, 0, -1, 0, "wrap");
        chk32 = 1'b0;

        // Reset while in FLUSH aborts the job silently
        fill_all(-3, 5, -15);
        start = 1'b1;
        k_len = 8'd1;
        tick();
        start = 1'b0;
        a_col = {4{16'hFFFD}};
        b_row = {4{16'h0005}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("abort in flush", 64'(busy && !bus.in_ready && !bus.out_valid), 64'd1);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        check_quiet("abort rst");
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (done || bus.out_valid || busy) seen++;
        end
        check_eq("abort silent", 64'(seen), 64'd0);
        run_job(1, 0, -1, 0, "post rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end
endmodule
